// File: rtl/branch_unit.sv
// branch_unit: multi-cycle ARM7 branch executor for the execute stage.
// Evaluates the condition once on accept, reads PC (and Rm for BX) through
// the shared regfile read port, then writes LR (BL/BLX) and the new PC.
// Optional feature macro: BRANCH_BX_EN (enables BX/BLX and the thumb bit).

module branch_unit #(
  parameter int XLEN     = 32,
  parameter int OFFSET_W = 24,
  parameter int PC_AHEAD = 8,
  parameter int INSN_B   = 4,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [3:0]          cond_code,
  input  logic [3:0]          flags,
  input  logic                link,
  input  logic                bx,
  input  logic [3:0]          rm,
  input  logic [OFFSET_W-1:0] offset,
  output logic                busy,
  output logic                done,
  output logic                taken,
  output logic                thumb,
  output logic                read_en,
  output logic [3:0]          read_reg,
  input  logic [XLEN-1:0]     read_value,
  output logic                write_en,
  output logic [3:0]          write_reg,
  output logic [XLEN-1:0]     write_value
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_RD_PC   = 4'd1;
  localparam logic [3:0] S_WAIT_PC = 4'd2;
  localparam logic [3:0] S_WR_LR   = 4'd3;
`ifdef BRANCH_BX_EN
  localparam logic [3:0] S_RD_RM   = 4'd4;
  localparam logic [3:0] S_WAIT_RM = 4'd5;
`endif
  localparam logic [3:0] S_WR_PC   = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;

  logic [3:0]          r_state;
  logic [CNT_W-1:0]    r_waitCnt;
  logic                r_taken;
  logic                r_link;
  logic [OFFSET_W-1:0] r_offset;
  logic [XLEN-1:0]     r_pc;

  logic                w_condPass;
  logic                w_waitLast;
  logic [XLEN-1:0]     w_offsetExt;
  logic [XLEN-1:0]     w_seqPc;
  logic [XLEN-1:0]     w_target;
  logic [XLEN-1:0]     w_pcValue;

`ifdef BRANCH_BX_EN
  logic                r_bx;
  logic [3:0]          r_rm;
  logic [XLEN-1:0]     r_rmVal;
  logic                r_thumb;
  logic                w_goBx;

  assign w_goBx = r_taken & r_bx;
  assign thumb  = r_thumb;
`else
  logic                w_unusedBx;

  assign w_unusedBx = ^{bx, rm};
  assign thumb      = 1'b0;
`endif

  assign w_waitLast  = (r_waitCnt == CNT_W'(READ_LAT - 1));
  assign w_offsetExt = {{(XLEN-OFFSET_W){r_offset[OFFSET_W-1]}}, r_offset};
  assign w_seqPc     = r_pc + XLEN'(INSN_B);
  assign w_target    = r_pc + XLEN'(PC_AHEAD) + (w_offsetExt << 2);

  // Full ARM condition table on the live inputs; only used at accept time
  always_comb begin
    w_condPass = 1'b0;
    case (cond_code)
      4'h0: w_condPass = flags[2];
      4'h1: w_condPass = ~flags[2];
      4'h2: w_condPass = flags[1];
      4'h3: w_condPass = ~flags[1];
      4'h4: w_condPass = flags[3];
      4'h5: w_condPass = ~flags[3];
      4'h6: w_condPass = flags[0];
      4'h7: w_condPass = ~flags[0];
      4'h8: w_condPass = flags[1] & ~flags[2];
      4'h9: w_condPass = ~flags[1] | flags[2];
      4'hA: w_condPass = (flags[3] == flags[0]);
      4'hB: w_condPass = (flags[3] != flags[0]);
      4'hC: w_condPass = ~flags[2] & (flags[3] == flags[0]);
      4'hD: w_condPass = flags[2] | (flags[3] != flags[0]);
      4'hE: w_condPass = 1'b1;
      default: w_condPass = 1'b0;
    endcase
  end

  // Select the final PC: sequential when not taken, Rm for BX, else PC-relative target
  always_comb begin
    w_pcValue = w_target;
    if (!r_taken) begin
      w_pcValue = w_seqPc;
    end
`ifdef BRANCH_BX_EN
    else if (r_bx) begin
      w_pcValue = {r_rmVal[XLEN-1:1], 1'b0};
    end
`endif
  end

  // Sequencer: walks read PC, optional LR write, optional Rm read, PC write, done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_waitCnt <= '0;
      r_taken   <= 1'b0;
      r_link    <= 1'b0;
      r_offset  <= '0;
      r_pc      <= '0;
`ifdef BRANCH_BX_EN
      r_bx      <= 1'b0;
      r_rm      <= 4'd0;
      r_rmVal   <= '0;
      r_thumb   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_taken  <= w_condPass;
            r_link   <= link;
            r_offset <= offset;
`ifdef BRANCH_BX_EN
            r_bx     <= bx;
            r_rm     <= rm;
`endif
            r_state  <= S_RD_PC;
          end
        end
        S_RD_PC: begin
          r_waitCnt <= '0;
          r_state   <= S_WAIT_PC;
        end
        S_WAIT_PC: begin
          if (w_waitLast) begin
            r_pc <= read_value;
            if (r_taken && r_link) begin
              r_state <= S_WR_LR;
            end else begin
`ifdef BRANCH_BX_EN
              r_state <= w_goBx ? S_RD_RM : S_WR_PC;
`else
              r_state <= S_WR_PC;
`endif
            end
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        S_WR_LR: begin
`ifdef BRANCH_BX_EN
          r_state <= w_goBx ? S_RD_RM : S_WR_PC;
`else
          r_state <= S_WR_PC;
`endif
        end
`ifdef BRANCH_BX_EN
        S_RD_RM: begin
          r_waitCnt <= '0;
          r_state   <= S_WAIT_RM;
        end
        S_WAIT_RM: begin
          if (w_waitLast) begin
            r_rmVal <= read_value;
            r_state <= S_WR_PC;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
`endif
        S_WR_PC: begin
`ifdef BRANCH_BX_EN
          if (w_goBx) begin
            r_thumb <= r_rmVal[0];
          end
`endif
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Regfile strobes and status are pure decodes of the state, so IDLE drives all zeros
  always_comb begin
    read_en     = 1'b0;
    read_reg    = 4'd0;
    write_en    = 1'b0;
    write_reg   = 4'd0;
    write_value = '0;
    case (r_state)
      S_RD_PC: begin
        read_en  = 1'b1;
        read_reg = 4'd15;
      end
`ifdef BRANCH_BX_EN
      S_RD_RM: begin
        read_en  = 1'b1;
        read_reg = r_rm;
      end
`endif
      S_WR_LR: begin
        write_en    = 1'b1;
        write_reg   = 4'd14;
        write_value = w_seqPc;
      end
      S_WR_PC: begin
        write_en    = 1'b1;
        write_reg   = 4'd15;
        write_value = w_pcValue;
      end
      default: begin
        read_en = 1'b0;
      end
    endcase
  end

  assign busy  = (r_state != S_IDLE);
  assign done  = (r_state == S_DONE);
  assign taken = done & r_taken;

endmodule

// File: tb/tb_branch_unit.sv
// tb_branch_unit: self-checking bench for branch_unit with a regfile model and
// a behavioural branch model (condition table, expected writes and latency).
// BX/BLX checks are included when BRANCH_BX_EN is defined.

module tb_branch_unit;

  localparam int LAT = 1;
`ifdef BRANCH_BX_EN
  localparam bit BX_ON = 1'b1;
`else
  localparam bit BX_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  condCode = 4'd0;
  logic [3:0]  nzcv = 4'd0;
  logic        linkIn = 1'b0;
  logic        bxIn = 1'b0;
  logic [3:0]  rmIn = 4'd0;
  logic [23:0] offsetIn = 24'd0;
  logic        busy, done, taken, thumb;
  logic        readEn, writeEn;
  logic [3:0]  readReg, writeReg;
  logic [31:0] readValue = 32'd0;
  logic [31:0] writeValue;

  logic [31:0] regs [16];
  int          testCount = 0;
  int          failCount = 0;
  logic        expThumb = 1'b0;

  branch_unit #(.READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .cond_code(condCode), .flags(nzcv),
    .link(linkIn), .bx(bxIn), .rm(rmIn), .offset(offsetIn),
    .busy(busy), .done(done), .taken(taken), .thumb(thumb),
    .read_en(readEn), .read_reg(readReg), .read_value(readValue),
    .write_en(writeEn), .write_reg(writeReg), .write_value(writeValue)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Regfile model: a read strobe returns the register contents, held until the next strobe
  always @(posedge clk) begin
    if (readEn) readValue <= regs[readReg];
  end

  // ARM condition semantics written from the flag meanings
  function automatic bit condPass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One comparison with an immediate assertion
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Run one branch and compare its transcript with the model
  task automatic applyStimulus(input string tag, input logic [31:0] pc, input logic [3:0] c,
                               input logic [3:0] f, input logic lnk, input logic doBx,
                               input logic [3:0] rIdx, input logic [31:0] rVal,
                               input logic [23:0] off, input bit repulse);
    logic [3:0]  expRegs[$];
    logic [31:0] expVals[$];
    logic [3:0]  gotRegs[$];
    logic [31:0] gotVals[$];
    logic [3:0]  gotReads[$];
    logic [3:0]  expReads[$];
    bit          expTaken, isBx, gotDone, gotTaken, gotThumb, overlap, busyLow;
    int          expLat, lat, offInt;
    logic [31:0] newPc;

    regs[15] = pc;
    if (doBx) regs[rIdx] = rVal;
    expTaken = condPass(c, f);
    isBx     = BX_ON && doBx && expTaken;
    offInt   = (off >= 24'h800000) ? int'(off) - (1 << 24) : int'(off);
    expReads.push_back(4'd15);
    if (isBx) expReads.push_back(rIdx);
    if (expTaken && lnk) begin
      expRegs.push_back(4'd14);
      expVals.push_back(pc + 32'd4);
    end
    if (!expTaken)   newPc = pc + 32'd4;
    else if (isBx)   newPc = rVal & 32'hFFFF_FFFE;
    else             newPc = pc + 32'd8 + 32'(offInt * 4);
    expRegs.push_back(4'd15);
    expVals.push_back(newPc);
    if (isBx) expThumb = rVal[0];
    expLat = 2 + LAT + ((expTaken && lnk) ? 1 : 0) + (isBx ? 1 + LAT : 0);

    @(negedge clk);
    en = 1'b1; condCode = c; nzcv = f; linkIn = lnk; bxIn = doBx; rmIn = rIdx; offsetIn = off;
    @(posedge clk);
    gotDone = 0; gotTaken = 0; gotThumb = 0; overlap = 0; busyLow = 0; lat = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        en = repulse;
        condCode = ~c; nzcv = ~f; linkIn = ~lnk; offsetIn = ~off;
      end else begin
        en = 1'b0;
      end
      if (!busy) busyLow = 1;
      if (readEn && writeEn) overlap = 1;
      if (readEn) gotReads.push_back(readReg);
      if (writeEn) begin
        gotRegs.push_back(writeReg);
        gotVals.push_back(writeValue);
      end
      if (done) begin
        gotDone = 1; lat = k; gotTaken = taken; gotThumb = thumb;
        break;
      end
      @(posedge clk);
    end
    en = 1'b0;
    checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, ".taken"}, {31'd0, gotTaken}, {31'd0, expTaken});
    checkOutput({tag, ".thumb"}, {31'd0, gotThumb}, {31'd0, expThumb});
    checkOutput({tag, ".busyHeld"}, {31'd0, busyLow}, 32'd0);
    checkOutput({tag, ".rdWrOverlap"}, {31'd0, overlap}, 32'd0);
    checkOutput({tag, ".nReads"}, 32'(gotReads.size()), 32'(expReads.size()));
    for (int i = 0; i < expReads.size() && i < gotReads.size(); i++)
      checkOutput($sformatf("%s.readReg%0d", tag, i), {28'd0, gotReads[i]}, {28'd0, expReads[i]});
    checkOutput({tag, ".nWrites"}, 32'(gotRegs.size()), 32'(expRegs.size()));
    for (int i = 0; i < expRegs.size() && i < gotRegs.size(); i++) begin
      checkOutput($sformatf("%s.writeReg%0d", tag, i), {28'd0, gotRegs[i]}, {28'd0, expRegs[i]});
      checkOutput($sformatf("%s.writeVal%0d", tag, i), gotVals[i], expVals[i]);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, ".busyDrop"}, {31'd0, busy}, 32'd0);
  endtask

  // Reset in WAIT_PC: outputs clear on the next cycle and no write ever appears
  task automatic applyResetAbort();
    int strayWrites;
    regs[15] = 32'h100;
    @(negedge clk);
    en = 1'b1; condCode = 4'hE; nzcv = 4'd0; linkIn = 1'b1; bxIn = 1'b0; offsetIn = 24'd2;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstAbort.outputs",
                {busy, done, taken, thumb, readEn, writeEn, readReg, writeReg, 18'd0},
                32'd0);
    checkOutput("rstAbort.writeValue", writeValue, 32'd0);
    rst = 1'b0;
    expThumb = 1'b0;
    strayWrites = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (writeEn || busy) strayWrites++;
    end
    checkOutput("rstAbort.idleAfter", 32'(strayWrites), 32'd0);
  endtask

  // Directed cases first, then randomized branches, then reset abort and recovery
  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.outputs",
                {busy, done, taken, thumb, readEn, writeEn, readReg, writeReg, 18'd0}, 32'd0);
    checkOutput("reset.writeValue", writeValue, 32'd0);
    rst = 1'b0;

    applyStimulus("bAl",    32'h100,      4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 32'd0, 24'h000002, 1'b0);
    applyStimulus("blBack", 32'h100,      4'hE, 4'h0, 1'b1, 1'b0, 4'd0, 32'd0, 24'hFFFFFE, 1'b0);
    applyStimulus("eqFail", 32'h100,      4'h0, 4'h0, 1'b1, 1'b0, 4'd0, 32'd0, 24'h000010, 1'b0);
    applyStimulus("nvFail", 32'h100,      4'hF, 4'hF, 1'b1, 1'b0, 4'd0, 32'd0, 24'h000010, 1'b0);
    applyStimulus("wrap",   32'hFFFFFFF8, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 32'd0, 24'h000000, 1'b1);
    applyStimulus("blRepulse", 32'h2000,  4'hE, 4'h0, 1'b1, 1'b0, 4'd0, 32'd0, 24'h000040, 1'b1);
`ifdef BRANCH_BX_EN
    applyStimulus("bx",     32'h100,      4'hE, 4'h0, 1'b0, 1'b1, 4'd3, 32'h2001, 24'd0, 1'b0);
    applyStimulus("blx",    32'h100,      4'hE, 4'h0, 1'b1, 1'b1, 4'd3, 32'h2001, 24'd0, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      logic [31:0] pc;
      logic [3:0]  c, f, ri;
      logic        l, b;
      pc = $urandom;
      c  = 4'($urandom_range(0, 15));
      f  = 4'($urandom_range(0, 15));
      l  = 1'($urandom_range(0, 1));
      b  = 1'($urandom_range(0, 1));
      ri = 4'($urandom_range(0, 13));
      applyStimulus($sformatf("rnd%0d", n), pc, c, f, l, b, ri, $urandom, 24'($urandom),
                    bit'($urandom_range(0, 1)));
    end

    applyResetAbort();
    applyStimulus("afterRst", 32'h100, 4'hE, 4'h0, 1'b0, 1'b0, 4'd0, 32'd0, 24'h000002, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // Hard time bound so the run always terminates
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
